// File: rtl/reg_bank_seq.sv
// reg_bank_seq: four-entry operand register bank feeding a downstream 4:1 nibble selector.
//
// Holds four WIDTH-bit operands (a/b/c/d) written through a ready/valid port and drives the
// selector's 2-bit sel either from a registered manual select (IDLE) or from an auto-scan FSM
// that steps sel 0->1->2->3, holding each value for SCAN_DWELL cycles.
//
// Ports:
//   clk_i          clock, all state changes on the rising edge
//   reset_i        synchronous active-high reset, overrides every other input
//   wr_en_i        write request (valid)
//   wr_addr_i      target register: 0=a 1=b 2=c 3=d
//   wr_data_i      write data
//   wr_ready_o     write accepted this cycle when wr_en_i & wr_ready_o
//   man_sel_i      manual select, followed while IDLE
//   scan_start_i   start auto-scan (level, acted on in IDLE only)
//   scan_stop_i    abort auto-scan
//   a_o..d_o       registered operands
//   sel_o          registered select
//   scan_busy_o    high while scanning
//   scan_done_o    one-cycle pulse on scan completion or abort
//
// Build option: define REG_BANK_SCAN_WRAP_EN to make the scan wrap 3->0 and run until
// scan_stop_i. Undefined (default): a single pass 0..3, then completion.

module reg_bank_seq #(
  parameter int unsigned      WIDTH      = 4,
  parameter int unsigned      SCAN_DWELL = 1,  // legal range 1..15
  parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             wr_en_i,
  input  logic [1:0]       wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic             wr_ready_o,
  input  logic [1:0]       man_sel_i,
  input  logic             scan_start_i,
  input  logic             scan_stop_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic [WIDTH-1:0] c_o,
  output logic [WIDTH-1:0] d_o,
  output logic [1:0]       sel_o,
  output logic             scan_busy_o,
  output logic             scan_done_o
);

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDone
  } state_e;

  localparam logic [3:0] CntLast = 4'(SCAN_DWELL - 1);

  state_e           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] ops_q [4];
  logic [WIDTH-1:0] ops_d [4];

  // Never overwrite the operand that is currently presented downstream during a scan.
  assign wr_ready_o = !((state_q == StScan) && (wr_addr_i == sel_q));

  always_comb begin
    ops_d = ops_q;
    if (wr_en_i && wr_ready_o) begin
      ops_d[wr_addr_i] = wr_data_i;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        sel_d = man_sel_i;
        // Stop wins over start, so asserting both leaves the bank idle.
        if (scan_start_i && !scan_stop_i) begin
          state_d = StScan;
          sel_d   = 2'd0;
          cnt_d   = 4'd0;
        end
      end
      StScan: begin
        if (scan_stop_i) begin
          state_d = StDone;
          cnt_d   = 4'd0;
        end else if (cnt_q == CntLast) begin
          cnt_d = 4'd0;
`ifdef REG_BANK_SCAN_WRAP_EN
          sel_d = sel_q + 2'd1;
`else
          // Last step of the single pass: keep sel at 3 through DONE.
          if (sel_q == 2'd3) begin
            state_d = StDone;
          end else begin
            sel_d = sel_q + 2'd1;
          end
`endif
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      sel_q   <= 2'd0;
      cnt_q   <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        ops_q[i] <= RESET_VAL;
      end
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      ops_q   <= ops_d;
    end
  end

  assign a_o         = ops_q[0];
  assign b_o         = ops_q[1];
  assign c_o         = ops_q[2];
  assign d_o         = ops_q[3];
  assign sel_o       = sel_q;
  assign scan_busy_o = (state_q == StScan);
  assign scan_done_o = (state_q == StDone);

endmodule

// File: tb/tb_reg_bank_seq.sv
// Bench for reg_bank_seq: directed scenarios followed by random traffic, every cycle compared
// against a cycle-level model that tracks scan progress as elapsed cycles since start.

module tb_reg_bank_seq;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DWELL = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             wr_en;
  logic [1:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             wr_ready;
  logic [1:0]       man_sel;
  logic             scan_start;
  logic             scan_stop;
  logic [WIDTH-1:0] a, b, c, d;
  logic [1:0]       sel;
  logic             scan_busy;
  logic             scan_done;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [WIDTH-1:0] m_regs [4];
  logic [1:0]       m_sel;
  bit               m_scan;
  bit               m_done;
  int               m_t;

  always #5 clk = ~clk;

  reg_bank_seq #(
    .WIDTH     (WIDTH),
    .SCAN_DWELL(DWELL),
    .RESET_VAL (4'h0)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .wr_en_i     (wr_en),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .wr_ready_o  (wr_ready),
    .man_sel_i   (man_sel),
    .scan_start_i(scan_start),
    .scan_stop_i (scan_stop),
    .a_o         (a),
    .b_o         (b),
    .c_o         (c),
    .d_o         (d),
    .sel_o       (sel),
    .scan_busy_o (scan_busy),
    .scan_done_o (scan_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    return !(m_scan && (wr_addr == m_sel));
  endfunction

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    bit rdy;
    rdy = model_ready();
    if (reset) begin
      for (int i = 0; i < 4; i++) m_regs[i] = 4'h0;
      m_sel  = 2'd0;
      m_scan = 1'b0;
      m_done = 1'b0;
      m_t    = 0;
    end else begin
      if (wr_en && rdy) m_regs[wr_addr] = wr_data;
      if (m_done) begin
        m_done = 1'b0;
      end else if (m_scan) begin
        if (scan_stop) begin
          m_scan = 1'b0;
          m_done = 1'b0;
          m_done = 1'b1;
        end else begin
          m_t++;
`ifdef REG_BANK_SCAN_WRAP_EN
          m_sel = 2'((m_t / DWELL) % 4);
`else
          if (m_t == 4 * DWELL) begin
            m_scan = 1'b0;
            m_done = 1'b1;
          end else begin
            m_sel = 2'((m_t / DWELL) % 4);
          end
`endif
        end
      end else begin
        m_sel = man_sel;
        if (scan_start && !scan_stop) begin
          m_scan = 1'b1;
          m_t    = 0;
          m_sel  = 2'd0;
        end
      end
    end
  endtask

  // Compare all outputs mid-cycle, then take one clock edge.
  task automatic tick();
    @(negedge clk);
    check_eq("a", a, m_regs[0]);
    check_eq("b", b, m_regs[1]);
    check_eq("c", c, m_regs[2]);
    check_eq("d", d, m_regs[3]);
    check_eq("sel", sel, m_sel);
    check_eq("busy", scan_busy, m_scan);
    check_eq("done", scan_done, m_done);
    check_eq("ready", wr_ready, model_ready());
    @(posedge clk);
    model_step();
    #1;
  endtask

  logic [WIDTH-1:0] wvals [4];
  logic [1:0]       seq [8];

  initial begin
    wvals = '{4'h3, 4'h5, 4'hA, 4'hF};
    seq   = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
    for (int i = 0; i < 4; i++) m_regs[i] = 4'h0;
    m_sel = 2'd0; m_scan = 1'b0; m_done = 1'b0; m_t = 0;

    // Reset with a pending write that must be discarded.
    reset = 1'b1; wr_en = 1'b1; wr_addr = 2'd0; wr_data = 4'h9;
    man_sel = 2'd1; scan_start = 1'b1; scan_stop = 1'b0;
    @(posedge clk); #1;
    tick(); tick();
    check_eq("rst_a", a, 4'h0);
    check_eq("rst_sel", sel, 2'd0);
    check_eq("rst_busy", scan_busy, 1'b0);
    check_eq("rst_done", scan_done, 1'b0);
    reset = 1'b0; wr_en = 1'b0; scan_start = 1'b0; man_sel = 2'd0;

    // Writes in IDLE.
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = 2'(i); wr_data = wvals[i];
      tick();
    end
    wr_en = 1'b0;
    check_eq("wr_a", a, 4'h3);
    check_eq("wr_d", d, 4'hF);
    man_sel = 2'd2;
    tick();
    check_eq("man_sel", sel, 2'd2);
    man_sel = 2'd0;

    // Full single pass.
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    check_eq("scan_sel0", sel, seq[0]);
    for (int k = 1; k < 8; k++) begin
      tick();
      check_eq("scan_seq", sel, seq[k]);
    end
    tick();
`ifndef REG_BANK_SCAN_WRAP_EN
    check_eq("scan_done", scan_done, 1'b1);
    check_eq("done_sel", sel, 2'd3);
`endif
    tick();
    check_eq("done_pulse", scan_done, 1'b0);
    tick(); tick();

    // Write stall on the presented operand.
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    tick(); tick();
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 4'h7;
    #1;
    check_eq("stall_rdy", wr_ready, 1'b0);
    tick();
    check_eq("stall_b", b, 4'h5);
    tick();
    check_eq("stall_sel2", sel, 2'd2);
    check_eq("stall_rdy2", wr_ready, 1'b1);
    tick();
    wr_en = 1'b0;
    check_eq("stall_acc", b, 4'h7);

    // Abort at sel=2.
    scan_stop = 1'b1;
    tick();
    scan_stop = 1'b0;
    check_eq("abort_done", scan_done, 1'b1);
    check_eq("abort_sel", sel, 2'd2);
    tick();
    scan_start = 1'b1; scan_stop = 1'b1;
    tick();
    check_eq("startstop", scan_busy, 1'b0);
    scan_start = 1'b0; scan_stop = 1'b0;

    // Reset mid-scan.
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check_eq("mid_sel2", sel, 2'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("mid_rst_sel", sel, 2'd0);
    check_eq("mid_rst_b", b, 4'h0);
    check_eq("mid_rst_busy", scan_busy, 1'b0);

`ifdef REG_BANK_SCAN_WRAP_EN
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    check_eq("wrap_busy", scan_busy, 1'b1);
    scan_stop = 1'b1;
    tick();
    scan_stop = 1'b0;
    check_eq("wrap_done", scan_done, 1'b1);
`endif

    // Random traffic.
    for (int n = 0; n < 2000; n++) begin
      reset      = ($urandom_range(0, 99) == 0);
      wr_en      = $urandom_range(0, 1);
      wr_addr    = 2'($urandom_range(0, 3));
      wr_data    = 4'($urandom_range(0, 15));
      man_sel    = 2'($urandom_range(0, 3));
      scan_start = ($urandom_range(0, 7) == 0);
      scan_stop  = ($urandom_range(0, 19) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
